// File: rtl/tow_match_ctrl.sv
// rtl/tow_match_ctrl.sv - Tug-of-War match sequencer: wait, dark, play, gloat rounds until a side wins the match.
module tow_match_ctrl #(
  parameter int WAIT_TICKS    = 2,
  parameter int GLOAT_TICKS   = 2,
  parameter int MIN_DARK      = 1,
  parameter int MAX_DARK      = 8,
  parameter int ROUNDS_TO_WIN = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 slowen_i,
  input  logic                                 rand_i,
  input  logic                                 winrnd_i,
  input  logic                                 win_side_i,
  input  logic                                 new_match_i,
  output logic                                 leds_on_o,
  output logic                                 clr_o,
  output logic [1:0]                           led_ctrl_o,
  output logic [$clog2(ROUNDS_TO_WIN+1)-1:0]   score_l_o,
  output logic [$clog2(ROUNDS_TO_WIN+1)-1:0]   score_r_o,
  output logic                                 match_over_o,
  output logic                                 winner_o
);

  localparam int MAX_AB = (WAIT_TICKS > GLOAT_TICKS) ? WAIT_TICKS : GLOAT_TICKS;
  localparam int MAX_T  = (MAX_AB > MAX_DARK) ? MAX_AB : MAX_DARK;
  localparam int CNT_W  = $clog2(MAX_T + 1);
  localparam int SC_W   = $clog2(ROUNDS_TO_WIN + 1);

  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_TICKS - 1);
  localparam logic [CNT_W-1:0] GLOAT_LAST = CNT_W'(GLOAT_TICKS - 1);
  localparam logic [CNT_W:0]   DARK_MIN   = (CNT_W+1)'(MIN_DARK);
  localparam logic [CNT_W:0]   DARK_MAX   = (CNT_W+1)'(MAX_DARK);
  localparam logic [SC_W-1:0]  WIN_SC     = SC_W'(ROUNDS_TO_WIN);
  localparam logic [SC_W-1:0]  SC_ONE     = SC_W'(1);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT      = 3'd1,
    S_DARK      = 3'd2,
    S_PLAY      = 3'd3,
    S_GLOAT     = 3'd4,
    S_MATCH_END = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic [SC_W-1:0]  score_l_q, score_l_d, score_r_q, score_r_d;
  logic             fs_q, fs_d;
  logic             winner_q, winner_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
      fs_q      <= 1'b0;
      winner_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      fs_q      <= fs_d;
      winner_q  <= winner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    fs_d         = fs_q;
    winner_d     = winner_q;
    cnt_inc      = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    leds_on_o    = 1'b1;
    clr_o        = 1'b1;
    led_ctrl_o   = 2'b11;
    match_over_o = 1'b0;

    case (state_q)
      S_RESET: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end

      S_WAIT: begin
        if (slowen_i) begin
          if (cnt_q == WAIT_LAST) begin
            state_d = S_DARK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
      end

      S_DARK: begin
        leds_on_o  = 1'b0;
        clr_o      = 1'b0;
        led_ctrl_o = 2'b00;
        // A press while dark is a false start: the other side takes the point.
        if (winrnd_i) begin
          if (win_side_i) begin
            score_l_d = (score_l_q == WIN_SC) ? score_l_q : score_l_q + SC_ONE;
          end else begin
            score_r_d = (score_r_q == WIN_SC) ? score_r_q : score_r_q + SC_ONE;
          end
          fs_d    = 1'b1;
          state_d = S_GLOAT;
          cnt_d   = '0;
        end else if (slowen_i) begin
          cnt_d = cnt_inc[CNT_W-1:0];
          if (cnt_inc >= DARK_MAX) begin
            state_d = S_PLAY;
            cnt_d   = '0;
          end else if (cnt_inc > DARK_MIN && rand_i) begin
            state_d = S_PLAY;
            cnt_d   = '0;
          end
        end
      end

      S_PLAY: begin
        clr_o      = 1'b0;
        led_ctrl_o = 2'b10;
        if (winrnd_i) begin
          if (win_side_i) begin
            score_r_d = (score_r_q == WIN_SC) ? score_r_q : score_r_q + SC_ONE;
          end else begin
            score_l_d = (score_l_q == WIN_SC) ? score_l_q : score_l_q + SC_ONE;
          end
          fs_d    = 1'b0;
          state_d = S_GLOAT;
          cnt_d   = '0;
        end
      end

      S_GLOAT: begin
        led_ctrl_o = fs_q ? 2'b01 : 2'b10;
        if (slowen_i) begin
          if (cnt_q == GLOAT_LAST) begin
            cnt_d = '0;
            fs_d  = 1'b0;
            if (score_l_q == WIN_SC || score_r_q == WIN_SC) begin
              state_d  = S_MATCH_END;
              winner_d = (score_r_q == WIN_SC);
            end else begin
              state_d = S_DARK;
            end
          end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
      end

      S_MATCH_END: begin
        led_ctrl_o   = 2'b10;
        match_over_o = 1'b1;
        if (new_match_i) begin
          state_d   = S_WAIT;
          score_l_d = '0;
          score_r_d = '0;
          winner_d  = 1'b0;
          cnt_d     = '0;
        end
      end

      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  assign score_l_o = score_l_q;
  assign score_r_o = score_r_q;
  assign winner_o  = winner_q;

endmodule

// File: tb/tb_tow_match_ctrl.sv
// tb/tb_tow_match_ctrl.sv - Scoreboard bench for tow_match_ctrl with default parameters.
module tb_tow_match_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       slowen = 1'b0, rand_b = 1'b0, winrnd = 1'b0, win_side = 1'b0, new_match = 1'b0;
  logic       leds_on, clr, match_over, winner;
  logic [1:0] led_ctrl, score_l, score_r;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [4:0] stim;
    logic [9:0] exp;
  } step_t;

  step_t      plan[$];
  logic [9:0] exp_q[$];
  logic [9:0] obs;

  // stimulus word: {slowen, rand, winrnd, win_side, new_match}
  localparam logic [4:0] SL   = 5'b10000;
  localparam logic [4:0] SLR  = 5'b11000;
  localparam logic [4:0] WL   = 5'b00100;
  localparam logic [4:0] WR   = 5'b00110;
  localparam logic [4:0] SLWL = 5'b10100;
  localparam logic [4:0] NM   = 5'b00001;

  assign obs = {leds_on, clr, led_ctrl, score_l, score_r, match_over, winner};

  always #5 clk = ~clk;

  tow_match_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .slowen_i     (slowen),
    .rand_i       (rand_b),
    .winrnd_i     (winrnd),
    .win_side_i   (win_side),
    .new_match_i  (new_match),
    .leds_on_o    (leds_on),
    .clr_o        (clr),
    .led_ctrl_o   (led_ctrl),
    .score_l_o    (score_l),
    .score_r_o    (score_r),
    .match_over_o (match_over),
    .winner_o     (winner)
  );

  function automatic logic [9:0] mk(input logic l, input logic c, input logic [1:0] lc,
                                    input int sl, input int sr, input logic mo, input logic w);
    return {l, c, lc, 2'(sl), 2'(sr), mo, w};
  endfunction

  function automatic logic [9:0] idle(input int sl, input int sr);
    return mk(1'b1, 1'b1, 2'b11, sl, sr, 1'b0, 1'b0);
  endfunction
  function automatic logic [9:0] dark(input int sl, input int sr);
    return mk(1'b0, 1'b0, 2'b00, sl, sr, 1'b0, 1'b0);
  endfunction
  function automatic logic [9:0] play(input int sl, input int sr);
    return mk(1'b1, 1'b0, 2'b10, sl, sr, 1'b0, 1'b0);
  endfunction
  function automatic logic [9:0] g10(input int sl, input int sr);
    return mk(1'b1, 1'b1, 2'b10, sl, sr, 1'b0, 1'b0);
  endfunction
  function automatic logic [9:0] g01(input int sl, input int sr);
    return mk(1'b1, 1'b1, 2'b01, sl, sr, 1'b0, 1'b0);
  endfunction
  function automatic logic [9:0] mend(input int sl, input int sr, input logic w);
    return mk(1'b1, 1'b1, 2'b10, sl, sr, 1'b1, w);
  endfunction

  task automatic cyc(input logic [4:0] s);
    @(negedge clk);
    {slowen, rand_b, winrnd, win_side, new_match} = s;
    @(posedge clk);
    #1;
    {slowen, rand_b, winrnd, win_side, new_match} = 5'b0;
  endtask

  task automatic add(input logic [4:0] s, input logic [9:0] x);
    plan.push_back('{stim: s, exp: x});
  endtask

  task automatic test_reset();
    logic [9:0] e;
    #1 rst = 1'b1;
    exp_q.push_back(idle(0, 0));
    #1;
    e = exp_q.pop_front();
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL reset_hold: got %b expected %b", obs, e);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(idle(0, 0));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL reset_release: got %b expected %b", obs, e);
    end
  endtask

  task automatic test_wait_to_dark();
    step_t p;
    logic [9:0] e;
    int n = 0;
    add(SL, idle(0, 0));
    add(SL, dark(0, 0));
    while (plan.size() > 0) begin
      p = plan.pop_front();
      exp_q.push_back(p.exp);
      cyc(p.stim);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL wait_to_dark step %0d: got %b expected %b", n, obs, e);
      end
      n++;
    end
  endtask

  task automatic test_forced_play();
    step_t p;
    logic [9:0] e;
    int n = 0;
    for (int i = 0; i < 7; i++) add(SL, dark(0, 0));
    add(SL, play(0, 0));
    add(SL, play(0, 0));
    add(WL, g10(1, 0));
    add(SL, g10(1, 0));
    add(SL, dark(1, 0));
    while (plan.size() > 0) begin
      p = plan.pop_front();
      exp_q.push_back(p.exp);
      cyc(p.stim);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL forced_play step %0d: got %b expected %b", n, obs, e);
      end
      n++;
    end
  endtask

  task automatic test_rand_start();
    step_t p;
    logic [9:0] e;
    int n = 0;
    add(SLR, dark(1, 0));
    add(SLR, play(1, 0));
    add(WR, g10(1, 1));
    add(WL, g10(1, 1));
    add(SL, g10(1, 1));
    add(SL, dark(1, 1));
    while (plan.size() > 0) begin
      p = plan.pop_front();
      exp_q.push_back(p.exp);
      cyc(p.stim);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL rand_start step %0d: got %b expected %b", n, obs, e);
      end
      n++;
    end
  endtask

  task automatic test_false_start();
    step_t p;
    logic [9:0] e;
    int n = 0;
    add(SLWL, g01(1, 2));
    add(SL, g01(1, 2));
    add(SL, dark(1, 2));
    while (plan.size() > 0) begin
      p = plan.pop_front();
      exp_q.push_back(p.exp);
      cyc(p.stim);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL false_start step %0d: got %b expected %b", n, obs, e);
      end
      n++;
    end
  endtask

  task automatic test_match_win();
    step_t p;
    logic [9:0] e;
    int n = 0;
    add(SLR, dark(1, 2));
    add(SLR, play(1, 2));
    add(WR, g10(1, 3));
    add(SL, g10(1, 3));
    add(SL, mend(1, 3, 1'b1));
    add(WL, mend(1, 3, 1'b1));
    add(SLR, mend(1, 3, 1'b1));
    add(NM, idle(0, 0));
    while (plan.size() > 0) begin
      p = plan.pop_front();
      exp_q.push_back(p.exp);
      cyc(p.stim);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL match_win step %0d: got %b expected %b", n, obs, e);
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    step_t p;
    logic [9:0] e;
    int n = 0;
    add(SL, idle(0, 0));
    add(SL, dark(0, 0));
    for (int k = 1; k <= 3; k++) begin
      add(WR, g01(k, 0));
      add(SL, g01(k, 0));
      add(SL, (k < 3) ? dark(k, 0) : mend(3, 0, 1'b0));
    end
    add(WR, mend(3, 0, 1'b0));
    add(NM, idle(0, 0));
    while (plan.size() > 0) begin
      p = plan.pop_front();
      exp_q.push_back(p.exp);
      cyc(p.stim);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL back_to_back step %0d: got %b expected %b", n, obs, e);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid_play();
    step_t p;
    logic [9:0] e;
    int n = 0;
    add(SL, idle(0, 0));
    add(SL, dark(0, 0));
    for (int k = 1; k <= 2; k++) begin
      add(SLR, dark(k - 1, 0));
      add(SLR, play(k - 1, 0));
      add(WL, g10(k, 0));
      add(SL, g10(k, 0));
      add(SL, dark(k, 0));
    end
    add(SLR, dark(2, 0));
    add(SLR, play(2, 0));
    while (plan.size() > 0) begin
      p = plan.pop_front();
      exp_q.push_back(p.exp);
      cyc(p.stim);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL reset_mid_play step %0d: got %b expected %b", n, obs, e);
      end
      n++;
    end
    // Assert reset between clock edges; outputs must drop back immediately.
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(idle(0, 0));
    #1;
    e = exp_q.pop_front();
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL reset_mid_play async: got %b expected %b", obs, e);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(idle(0, 0));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL reset_mid_play release: got %b expected %b", obs, e);
    end
  endtask

  initial begin
    test_reset();
    test_wait_to_dark();
    test_forced_play();
    test_rand_start();
    test_false_start();
    test_match_win();
    test_back_to_back();
    test_reset_mid_play();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
